// File: rtl/multi_alarm_timekeeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_alarm_timekeeper                                                   |
// | 1 Hz timebase, h/m/s counters, NUM_ALARMS snoozable alarms and buzzer.   |
// | Optional: define TIMEKEEPER_CHIME_EN for a one-second hourly chime.      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module multi_alarm_timekeeper #(
   parameter int CLK_HZ     = 31500000,
   parameter int BUZZ_HZ    = 3150,
   parameter int NUM_ALARMS = 2,
   parameter int HOUR_24    = 0,
   parameter int SNOOZE_MIN = 5,
   parameter int RING_SECS  = 60
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    sec_inc,
   input  logic                    min_inc,
   input  logic                    hr_inc,
   input  logic [NUM_ALARMS-1:0]   al_inc,
   input  logic [NUM_ALARMS-1:0]   al_toggle,
   input  logic                    snooze,
   output logic [5:0]              seconds,
   output logic [5:0]              minutes,
   output logic [4:0]              hours,
   output logic [6*NUM_ALARMS-1:0] al_minutes,
   output logic [5*NUM_ALARMS-1:0] al_hours,
   output logic [NUM_ALARMS-1:0]   al_enabled,
   output logic [NUM_ALARMS-1:0]   ringing,
   output logic                    tick_1hz,
   output logic                    buzzer_out
);
   localparam int c_pw       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int c_half_raw = CLK_HZ / (2 * BUZZ_HZ);
   localparam int c_half     = (c_half_raw < 1) ? 1 : c_half_raw;
   localparam int c_bw       = (c_half > 1) ? $clog2(c_half) : 1;
   localparam int c_rw       = $clog2(RING_SECS + 1);
   localparam logic [c_pw-1:0] c_presc_last = c_pw'(CLK_HZ - 1);
   localparam logic [c_pw-1:0] c_presc_pre  = c_pw'(CLK_HZ - 2);
   localparam logic [c_pw-1:0] c_presc_mid  = c_pw'(CLK_HZ / 2);
   localparam logic [c_bw-1:0] c_buzz_last  = c_bw'(c_half - 1);
   localparam logic [c_rw-1:0] c_ring_last  = c_rw'(RING_SECS - 1);
   localparam logic [4:0]      c_hour_max   = (HOUR_24 != 0) ? 5'd23 : 5'd11;
   localparam logic [6:0]      c_snooze     = 7'(SNOOZE_MIN);

   typedef enum logic [1:0] {
      S_OFF     = 2'd0,
      S_ARMED   = 2'd1,
      S_RINGING = 2'd2,
      S_SNOOZED = 2'd3
   } state_t;

   function automatic logic [4:0] f_hr_next(input logic [4:0] h);
      return (h == c_hour_max) ? 5'd0 : h + 5'd1;
   endfunction

   function automatic logic [5:0] f_60_next(input logic [5:0] v);
      return (v == 6'd59) ? 6'd0 : v + 6'd1;
   endfunction

   logic [c_pw-1:0] r_presc;
   logic            r_tick, r_tick_d;

   // r_tick is registered one count early so it lines up with count == CLK_HZ-1
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_presc  <= '0;
         r_tick   <= 1'b0;
         r_tick_d <= 1'b0;
      end else begin
         r_presc  <= (r_presc == c_presc_last) ? '0 : r_presc + 1'b1;
         r_tick   <= (r_presc == c_presc_pre);
         r_tick_d <= r_tick;
      end
   end

   logic [5:0] r_sec, r_min;
   logic [4:0] r_hr;
   logic       r_sec_pend, r_min_pend, r_hr_pend;
   logic       w_sec_do, w_min_do, w_hr_do;

   assign w_sec_do = !r_tick && (r_sec_pend || sec_inc);
   assign w_min_do = !r_tick && (r_min_pend || min_inc);
   assign w_hr_do  = !r_tick && (r_hr_pend  || hr_inc);

   // A pulse arriving on a tick is held one cycle; a pending pulse plus a new
   // one applies the pending one now and keeps the new one pending.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sec      <= '0;
         r_min      <= '0;
         r_hr       <= '0;
         r_sec_pend <= 1'b0;
         r_min_pend <= 1'b0;
         r_hr_pend  <= 1'b0;
      end else begin
         r_sec_pend <= r_tick ? (r_sec_pend | sec_inc) : (r_sec_pend & sec_inc);
         r_min_pend <= r_tick ? (r_min_pend | min_inc) : (r_min_pend & min_inc);
         r_hr_pend  <= r_tick ? (r_hr_pend  | hr_inc)  : (r_hr_pend  & hr_inc);
         if (r_tick) begin
            r_sec <= f_60_next(r_sec);
            if (r_sec == 6'd59) begin
               r_min <= f_60_next(r_min);
               if (r_min == 6'd59)
                  r_hr <= f_hr_next(r_hr);
            end
         end else begin
            if (w_sec_do) r_sec <= f_60_next(r_sec);
            if (w_min_do) r_min <= f_60_next(r_min);
            if (w_hr_do)  r_hr  <= f_hr_next(r_hr);
         end
      end
   end

   logic [6:0] w_snz_sum;
   logic       w_snz_carry;
   logic [5:0] w_snz_m;
   logic [4:0] w_snz_h;
   logic       w_match_slot;

   assign w_snz_sum    = {1'b0, r_min} + c_snooze;
   assign w_snz_carry  = (w_snz_sum >= 7'd60);
   assign w_snz_m      = w_snz_carry ? 6'(w_snz_sum - 7'd60) : w_snz_sum[5:0];
   assign w_snz_h      = w_snz_carry ? f_hr_next(r_hr) : r_hr;
   assign w_match_slot = r_tick_d && (r_sec == 6'd0);

   generate
      for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_alarm
         state_t          r_state, w_state_nxt;
         logic [5:0]      r_al_m, r_snz_m;
         logic [4:0]      r_al_h, r_snz_h;
         logic [c_rw-1:0] r_ring_cnt;
         logic            w_al_match, w_snz_match, w_ring_done, w_inc_ok;

         assign w_al_match  = w_match_slot && (r_hr == r_al_h) && (r_min == r_al_m);
         assign w_snz_match = w_match_slot && (r_hr == r_snz_h) && (r_min == r_snz_m);
         assign w_ring_done = r_tick && (r_ring_cnt == c_ring_last);
         assign w_inc_ok    = al_inc[i] && ((r_state == S_OFF) || (r_state == S_ARMED));

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) r_state <= S_OFF;
            else          r_state <= w_state_nxt;
         end

         always_comb begin
            w_state_nxt = r_state;
            if (al_toggle[i]) begin
               w_state_nxt = (r_state == S_OFF) ? S_ARMED : S_OFF;
            end else begin
               case (r_state)
                  S_ARMED:   if (w_al_match) w_state_nxt = S_RINGING;
                  S_RINGING: begin
                     if (snooze)           w_state_nxt = S_SNOOZED;
                     else if (w_ring_done) w_state_nxt = S_ARMED;
                  end
                  S_SNOOZED: if (w_snz_match) w_state_nxt = S_RINGING;
                  default:   w_state_nxt = r_state;
               endcase
            end
         end

         // Ring counter idles at zero outside RINGING so every entry starts fresh
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_al_m     <= '0;
               r_al_h     <= '0;
               r_snz_m    <= '0;
               r_snz_h    <= '0;
               r_ring_cnt <= '0;
            end else begin
               if (w_inc_ok) begin
                  if (r_al_m == 6'd50) begin
                     r_al_m <= 6'd0;
                     r_al_h <= f_hr_next(r_al_h);
                  end else begin
                     r_al_m <= r_al_m + 6'd10;
                  end
               end
               if (al_toggle[i]) begin
                  r_snz_m <= '0;
                  r_snz_h <= '0;
               end else if ((r_state == S_RINGING) && snooze) begin
                  r_snz_m <= w_snz_m;
                  r_snz_h <= w_snz_h;
               end
               if (r_state != S_RINGING) r_ring_cnt <= '0;
               else if (r_tick)          r_ring_cnt <= r_ring_cnt + 1'b1;
            end
         end

         assign al_minutes[6*i +: 6] = r_al_m;
         assign al_hours[5*i +: 5]   = r_al_h;
         assign al_enabled[i]        = (r_state != S_OFF);
         assign ringing[i]           = (r_state == S_RINGING);
      end
   endgenerate

   logic [c_bw-1:0] r_buzz_cnt;
   logic            r_wave, r_buzz, w_chime;

`ifdef TIMEKEEPER_CHIME_EN
   logic r_chime;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      r_chime <= 1'b0;
      else if (r_tick_d) r_chime <= (r_min == 6'd0) && (r_sec == 6'd0);
   end
   assign w_chime = r_chime;
`else
   assign w_chime = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_buzz_cnt <= '0;
         r_wave     <= 1'b0;
         r_buzz     <= 1'b0;
      end else begin
         r_buzz_cnt <= (r_buzz_cnt == c_buzz_last) ? '0 : r_buzz_cnt + 1'b1;
         if (r_buzz_cnt == c_buzz_last) r_wave <= ~r_wave;
         r_buzz <= r_wave && (((|ringing) && (r_presc < c_presc_mid)) || w_chime);
      end
   end

   assign seconds    = r_sec;
   assign minutes    = r_min;
   assign hours      = r_hr;
   assign tick_1hz   = r_tick;
   assign buzzer_out = r_buzz;
endmodule
`default_nettype wire

// File: tb/tb_multi_alarm_timekeeper.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for multi_alarm_timekeeper (CLK_HZ=10, two alarm channels,
// a second 24 h instance sharing the seconds/minutes buttons).
module tb_multi_alarm_timekeeper;
   localparam int NA = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic sec_inc = 1'b0, min_inc = 1'b0, hr_inc = 1'b0, hr_inc24 = 1'b0, snooze = 1'b0;
   logic [NA-1:0] al_inc = '0, al_toggle = '0;

   logic [5:0]      seconds, minutes, sec24, min24;
   logic [4:0]      hours, hr24;
   logic [6*NA-1:0] al_minutes, alm24;
   logic [5*NA-1:0] al_hours, alh24;
   logic [NA-1:0]   al_enabled, ringing, ale24, ring24;
   logic            tick_1hz, buzzer_out, tick24, buzz24;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int cnt;
   logic prev;

   always #5 clk = ~clk;

   multi_alarm_timekeeper #(.CLK_HZ(10), .BUZZ_HZ(5), .NUM_ALARMS(NA), .HOUR_24(0),
                            .SNOOZE_MIN(5), .RING_SECS(60)) dut (
      .clk(clk), .reset_n(reset_n), .sec_inc(sec_inc), .min_inc(min_inc), .hr_inc(hr_inc),
      .al_inc(al_inc), .al_toggle(al_toggle), .snooze(snooze),
      .seconds(seconds), .minutes(minutes), .hours(hours),
      .al_minutes(al_minutes), .al_hours(al_hours), .al_enabled(al_enabled),
      .ringing(ringing), .tick_1hz(tick_1hz), .buzzer_out(buzzer_out));

   multi_alarm_timekeeper #(.CLK_HZ(10), .BUZZ_HZ(5), .NUM_ALARMS(NA), .HOUR_24(1),
                            .SNOOZE_MIN(5), .RING_SECS(60)) dut24 (
      .clk(clk), .reset_n(reset_n), .sec_inc(sec_inc), .min_inc(min_inc), .hr_inc(hr_inc24),
      .al_inc('0), .al_toggle('0), .snooze(1'b0),
      .seconds(sec24), .minutes(min24), .hours(hr24),
      .al_minutes(alm24), .al_hours(alh24), .al_enabled(ale24),
      .ringing(ring24), .tick_1hz(tick24), .buzzer_out(buzz24));

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Inputs set before step() belong to period cyc; step() clears all pulses.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      sec_inc = 1'b0; min_inc = 1'b0; hr_inc = 1'b0; hr_inc24 = 1'b0;
      snooze = 1'b0; al_inc = '0; al_toggle = '0;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc = 0;
   endtask

   // Presses buttons on non-tick periods so that at tick period t the clock
   // reads h:m:s (seconds = presses + elapsed ticks); returns at period t.
   task automatic preload(input int h, input int m, input int s, input int h24);
      int t, avail, need, sp, hl, ml, h24l;
      t = -1;
      sp = 0;
      for (int k = cyc / 10; k < 60; k++) begin
         avail = 0;
         for (int c = cyc; c < 10 * k + 9; c++)
            if (c % 10 != 9) avail++;
         need = (h > m) ? h : m;
         if (h24 > need)   need = h24;
         if (s - k > need) need = s - k;
         if (t < 0 && s - k >= 0 && avail >= need) begin
            t  = 10 * k + 9;
            sp = s - k;
         end
      end
      if (t < 0) begin
         $display("FAIL preload: no schedule found for %0d:%0d:%0d", h, m, s);
         $fatal(1, "preload");
      end
      hl = h; ml = m; h24l = h24;
      while (cyc < t) begin
         if (cyc % 10 != 9) begin
            if (hl > 0)   begin hr_inc   = 1'b1; hl--;   end
            if (h24l > 0) begin hr_inc24 = 1'b1; h24l--; end
            if (ml > 0)   begin min_inc  = 1'b1; ml--;   end
            if (sp > 0)   begin sec_inc  = 1'b1; sp--;   end
         end
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset mid-count and first second
      do_reset();
      run_to(15);
      reset_n = 1'b0;
      #1;
      check("rst_seconds", int'(seconds), 0);
      check("rst_tick", int'(tick_1hz), 0);
      check("rst_hours", int'(hours), 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      cyc = 0;
      run_to(9);
      check("first_tick", int'(tick_1hz), 1);
      check("sec_before_tick", int'(seconds), 0);
      step();
      check("tick_one_cycle", int'(tick_1hz), 0);
      check("sec_after_tick", int'(seconds), 1);
      check("min_after_tick", int'(minutes), 0);
      check("hr_after_tick", int'(hours), 0);
      check("ring_after_rst", int'(ringing), 0);
      check("alen_after_rst", int'(al_enabled), 0);
      check("buzz_after_rst", int'(buzzer_out), 0);

      // Rollover 11:59:59 (12 h) and 23:59:59 (24 h)
      do_reset();
      preload(11, 59, 59, 23);
      check("pre12_h", int'(hours), 11);
      check("pre12_m", int'(minutes), 59);
      check("pre12_s", int'(seconds), 59);
      check("pre24_h", int'(hr24), 23);
      check("pre_tick", int'(tick_1hz), 1);
      step();
      check("roll12_h", int'(hours), 0);
      check("roll12_m", int'(minutes), 0);
      check("roll12_s", int'(seconds), 0);
      check("roll24_h", int'(hr24), 0);
      check("roll24_m", int'(min24), 0);
      check("roll24_s", int'(sec24), 0);
      check("d24_idle", int'({ale24, ring24, buzz24, tick24}), 0);
      check("d24_altime", int'({alm24, alh24}), 0);

      // sec_inc coincident with a tick, then pending + follow-on pulse
      do_reset();
      run_to(109);
      check("coin_pre_sec", int'(seconds), 10);
      sec_inc = 1'b1;
      step();
      check("coin_tick_sec", int'(seconds), 11);
      step();
      check("coin_pend_sec", int'(seconds), 12);
      check("coin_min", int'(minutes), 0);
      run_to(119);
      sec_inc = 1'b1;
      step();
      check("follow_sec0", int'(seconds), 13);
      sec_inc = 1'b1;
      step();
      check("follow_sec1", int'(seconds), 14);
      step();
      check("follow_sec2", int'(seconds), 15);

      // Channel 0: alarm 00:30, ring latency, al_inc ignored, ring timeout
      do_reset();
      al_toggle = 2'b01; step();
      al_inc = 2'b01; step();
      al_inc = 2'b01; step();
      al_inc = 2'b01; step();
      check("ch0_enabled", int'(al_enabled), 1);
      check("ch0_al_min", int'(al_minutes[5:0]), 30);
      check("ch0_al_hr", int'(al_hours[4:0]), 0);
      preload(0, 29, 59, 0);
      check("ch0_pre_s", int'(seconds), 59);
      step();
      check("ch0_match_min", int'(minutes), 30);
      check("ch0_not_yet", int'(ringing), 0);
      step();
      check("ch0_ringing", int'(ringing), 1);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (buzzer_out) cnt++;
      end
      check("ch0_buzz_active", int'(cnt > 0), 1);
      al_inc = 2'b01;
      step();
      check("ch0_inc_ignored", int'(al_minutes[5:0]), 30);
      run_to(669);
      check("ch0_ring_59", int'(ringing), 1);
      step();
      check("ch0_ring_done", int'(ringing), 0);
      check("ch0_armed", int'(al_enabled), 1);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (buzzer_out) cnt++;
      end
      check("ch0_buzz_quiet", cnt, 0);

      // Channel 1: alarm 01:50 (al_inc hour carry), snooze across the hour
      do_reset();
      al_toggle = 2'b10; step();
      for (int i = 0; i < 11; i++) begin
         al_inc = 2'b10;
         step();
      end
      check("ch1_al_min", int'(al_minutes[11:6]), 50);
      check("ch1_al_hr", int'(al_hours[9:5]), 1);
      check("ch1_enabled", int'(al_enabled), 2);
      preload(1, 49, 59, 0);
      step();
      step();
      check("ch1_ringing", int'(ringing), 2);
      for (int i = 0; i < 8; i++) begin
         min_inc = 1'b1;
         step();
      end
      check("ch1_set_min", int'(minutes), 58);
      check("ch1_set_hr", int'(hours), 1);
      step();
      snooze = 1'b1;
      step();
      check("ch1_snoozed_ring", int'(ringing), 0);
      check("ch1_snoozed_en", int'(al_enabled), 2);
      run_to(3080);
      check("snz_time_h", int'(hours), 2);
      check("snz_time_m", int'(minutes), 3);
      check("snz_time_s", int'(seconds), 0);
      check("snz_not_yet", int'(ringing), 0);
      step();
      check("snz_rerings", int'(ringing), 2);
      al_toggle = 2'b10;
      snooze = 1'b1;
      step();
      check("tog_snz_off", int'(al_enabled), 0);
      check("tog_snz_ring", int'(ringing), 0);

      // Top of the hour with no alarm enabled
      do_reset();
      preload(0, 59, 59, 0);
      step();
      check("hour_h", int'(hours), 1);
      cnt = 0;
      prev = buzzer_out;
      for (int i = 0; i < 12; i++) begin
         step();
         if (buzzer_out !== prev) cnt++;
         prev = buzzer_out;
      end
`ifdef TIMEKEEPER_CHIME_EN
      check("chime_toggles", int'(cnt >= 8), 1);
`else
      check("no_chime_toggles", cnt, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
